// File: rtl/rodata_load_unit.sv
// Load front end for the read-only data ROM: range/alignment checks, byte/half extraction, extension.
// Optional RODATA_MISALIGN_EN: split word-crossing loads into two ROM reads instead of faulting.
module rodata_load_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      ROM_BASE = 32'h0000_1000,
    parameter logic [XLEN-1:0]      ROM_SIZE = 32'h0000_0100
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [2:0]      i_req_funct3,
    output logic [XLEN-1:0] o_rom_addr,
    input  logic [XLEN-1:0] i_rom_rdata,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic [1:0]      o_rsp_cause
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RSP} state_e;

    state_e          state_q;
    logic            req_ready_q;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rom_addr_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [1:0]      rsp_cause_q;

    logic [XLEN:0]   size_s;
    logic [XLEN:0]   off_s;
    logic [XLEN:0]   last_off_s;
    logic            illegal_s;
    logic            fault_s;
    logic            misal_s;
    logic [XLEN-1:0] fit_raw_s;
    logic [1:0]      cause_d;
    logic [XLEN-1:0] data_d;

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] raw);
        case (f3)
            3'b000:  return {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  return {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // RD0 checks; offsets are XLEN+1 wide so addresses below the base or wrapping past the top fault.
    always_comb begin
        size_s = (XLEN+1)'(4);
        case (funct3_q[1:0])
            2'b00:   size_s = (XLEN+1)'(1);
            2'b01:   size_s = (XLEN+1)'(2);
            default: size_s = (XLEN+1)'(4);
        endcase
        off_s      = {1'b0, addr_q} - {1'b0, ROM_BASE};
        last_off_s = off_s + size_s - (XLEN+1)'(1);
        illegal_s  = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
        fault_s    = (off_s >= {1'b0, ROM_SIZE}) || (last_off_s >= {1'b0, ROM_SIZE});
        misal_s    = ((funct3_q[1:0] == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        if (illegal_s) begin
            cause_d = 2'd3;
        end else if (fault_s) begin
            cause_d = 2'd2;
        end else if (misal_s) begin
            cause_d = 2'd1;
        end else begin
            cause_d = 2'd0;
        end
        fit_raw_s = i_rom_rdata >> {addr_q[1:0], 3'b000};
        if (cause_d == 2'd0) begin
            data_d = load_extend(funct3_q, fit_raw_s);
        end else begin
            data_d = '0;
        end
    end

`ifdef RODATA_MISALIGN_EN
    logic [XLEN-1:0] low_buf_q;
    logic [XLEN-1:0] split_raw_s;

    // Second half of a split access: low word is buffered, high word is on the ROM port now.
    always_comb begin
        split_raw_s = XLEN'({i_rom_rdata, low_buf_q} >> {addr_q[1:0], 3'b000});
    end

    // Capture of the low word while the first ROM read is on the port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            low_buf_q <= '0;
        end else if (state_q == RD0) begin
            low_buf_q <= i_rom_rdata;
        end else begin
            low_buf_q <= low_buf_q;
        end
    end
`endif

    // Request/response sequencer with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cause_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid && req_ready_q) begin
                        addr_q      <= i_req_addr;
                        funct3_q    <= i_req_funct3;
                        rom_addr_q  <= {i_req_addr[XLEN-1:2], 2'b00};
                        req_ready_q <= 1'b0;
                        state_q     <= RD0;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                RD0: begin
`ifdef RODATA_MISALIGN_EN
                    if (cause_d == 2'd1) begin
                        rom_addr_q <= rom_addr_q + XLEN'(4);
                        state_q    <= RD1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= data_d;
                        rsp_cause_q <= cause_d;
                        state_q     <= RSP;
                    end
`else
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= data_d;
                    rsp_cause_q <= cause_d;
                    state_q     <= RSP;
`endif
                end
`ifdef RODATA_MISALIGN_EN
                RD1: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= load_extend(funct3_q, split_raw_s);
                    rsp_cause_q <= 2'd0;
                    state_q     <= RSP;
                end
`endif
                RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RSP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rom_addr  = rom_addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_cause = rsp_cause_q;

endmodule

// File: tb/tb_rodata_load_unit.sv
// Self-checking bench for rodata_load_unit: directed cases plus random loads against a byte-level model.
module tb_rodata_load_unit;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SIZE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [2:0]  i_req_funct3;
    logic [31:0] o_rom_addr;
    logic [31:0] rom_rdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_cause;

    int tests = 0;
    int fails = 0;

    rodata_load_unit #(.XLEN(32), .ROM_BASE(BASE), .ROM_SIZE(SIZE)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_funct3 (i_req_funct3),
        .o_rom_addr   (o_rom_addr),
        .i_rom_rdata  (rom_rdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_cause  (o_rsp_cause)
    );

    always #5 clk = ~clk;

    // ROM contents: byte at offset k holds k[7:0].
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return d[7:0];
    endfunction

    assign rom_rdata = {rom_byte(o_rom_addr + 32'd3), rom_byte(o_rom_addr + 32'd2),
                        rom_byte(o_rom_addr + 32'd1), rom_byte(o_rom_addr)};

`ifdef RODATA_MISALIGN_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // Reference: gather bytes one at a time, then extend arithmetically.
    function automatic void ref_load(input logic [31:0] a, input logic [2:0] f3,
                                     output logic [1:0] cause, output logic [31:0] data, output int lat);
        longint unsigned ua, sz, val;
        ua = a; data = 32'd0; lat = 1; cause = 2'd0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
            cause = 2'd3;
            return;
        end
        sz = (f3[1:0] == 2'd0) ? 64'd1 : (f3[1:0] == 2'd1) ? 64'd2 : 64'd4;
        if (ua < BASE || ua + sz > BASE + SIZE) begin
            cause = 2'd2;
            return;
        end
        if ((ua % 64'd4) + sz > 64'd4) begin
            if (SPLIT_EN) begin
                lat = 2;
            end else begin
                cause = 2'd1;
                return;
            end
        end
        val = 64'd0;
        for (int i = 0; i < int'(sz); i++) val = val | (longint'(rom_byte(a + 32'(i))) << (8 * i));
        if (!f3[2] && sz < 64'd4 && val[8*sz-1]) val = val | ~((64'd1 << (8 * sz)) - 64'd1);
        data = val[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One load transaction; hold = cycles the consumer stalls before accepting.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [1:0] exp_cause, input logic [31:0] exp_data,
                           input int exp_lat, input int hold);
        int cyc;
        logic [31:0] word;
        word = {a[31:2], 2'b00};
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(o_req_ready), 32'd1);
        i_rsp_ready = (hold == 0);
        i_req_valid = 1'b1; i_req_addr = a; i_req_funct3 = f3;
        @(posedge clk); #1;
        i_req_valid = 1'b0; i_req_addr = $urandom; i_req_funct3 = 3'($urandom);
        @(negedge clk);
        check({tag, " ready_rd0"}, 32'(o_req_ready), 32'd0);
        if (exp_cause == 2'd0) check({tag, " rom_addr0"}, o_rom_addr, word);
        cyc = 0;
        while (!o_rsp_valid && cyc < 8) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (exp_lat == 2 && cyc == 1) check({tag, " rom_addr1"}, o_rom_addr, word + 32'd4);
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " cause"}, 32'(o_rsp_cause), 32'(exp_cause));
        check({tag, " data"}, o_rsp_data, exp_data);
        check({tag, " ready_rsp"}, 32'(o_req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            i_req_valid = 1'b1; i_req_addr = BASE; i_req_funct3 = 3'b010;
            @(posedge clk); @(negedge clk);
            check({tag, " hold_valid"}, 32'(o_rsp_valid), 32'd1);
            check({tag, " hold_data"}, o_rsp_data, exp_data);
            check({tag, " hold_cause"}, 32'(o_rsp_cause), 32'(exp_cause));
            check({tag, " hold_ready"}, 32'(o_req_ready), 32'd0);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, " done_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, " done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    // Abort a request with reset, either in RD0 or while the response is waiting.
    task automatic reset_abort(input string tag, input bit in_rsp);
        @(negedge clk);
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1020; i_req_funct3 = 3'b010;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        if (in_rsp) begin
            @(posedge clk); @(negedge clk);
            check({tag, " pre_valid"}, 32'(o_rsp_valid), 32'd1);
        end
        i_rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); @(negedge clk);
            check({tag, " rst_valid"}, 32'(o_rsp_valid), 32'd0);
            check({tag, " rst_ready"}, 32'(o_req_ready), 32'd0);
        end
        i_rst = 1'b0;
        i_rsp_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); @(negedge clk);
            check({tag, " post_valid"}, 32'(o_rsp_valid), 32'd0);
            check({tag, " post_ready"}, 32'(o_req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        logic [1:0]  c;
        int          l;

        i_rst = 1'b1; i_req_valid = 1'b0; i_req_addr = 32'd0; i_req_funct3 = 3'd0; i_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(o_req_ready), 32'd0);
        check("reset valid", 32'(o_rsp_valid), 32'd0);
        check("reset data", o_rsp_data, 32'd0);
        check("reset cause", 32'(o_rsp_cause), 32'd0);
        check("reset rom_addr", o_rom_addr, 32'd0);
        i_rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("release ready", 32'(o_req_ready), 32'd1);

        do_load("lw_1004", 32'h0000_1004, 3'b010, 2'd0, 32'h0706_0504, 1, 0);
        do_load("lb_1080", 32'h0000_1080, 3'b000, 2'd0, 32'hFFFF_FF80, 1, 0);
        do_load("lbu_1080", 32'h0000_1080, 3'b100, 2'd0, 32'h0000_0080, 1, 0);
        do_load("lhu_10fe", 32'h0000_10FE, 3'b101, 2'd0, 32'h0000_FFFE, 1, 0);
        if (SPLIT_EN) do_load("lh_1003", 32'h0000_1003, 3'b001, 2'd0, 32'h0000_0403, 2, 0);
        else          do_load("lh_1003", 32'h0000_1003, 3'b001, 2'd1, 32'h0000_0000, 1, 0);
        do_load("lw_10fe", 32'h0000_10FE, 3'b010, 2'd2, 32'h0000_0000, 1, 0);
        do_load("lb_0fff", 32'h0000_0FFF, 3'b000, 2'd2, 32'h0000_0000, 1, 0);
        do_load("lw_ffff", 32'hFFFF_FFFF, 3'b010, 2'd2, 32'h0000_0000, 1, 0);
        do_load("f3_011", 32'h0000_1008, 3'b011, 2'd3, 32'h0000_0000, 1, 0);
        do_load("f3_110", 32'h0000_0004, 3'b110, 2'd3, 32'h0000_0000, 1, 0);
        do_load("lw_hold", 32'h0000_1010, 3'b010, 2'd0, 32'h1312_1110, 1, 5);

        for (int n = 0; n < 48; n++) begin
            if (n % 4 == 3) a = $urandom;
            else a = BASE - 32'd8 + 32'($urandom_range(0, 32'h110));
            f = 3'($urandom_range(0, 7));
            ref_load(a, f, c, d, l);
            do_load("random", a, f, c, d, l, $urandom_range(0, 2));
        end

        reset_abort("rst_rd0", 1'b0);
        do_load("lw_1000_a", 32'h0000_1000, 3'b010, 2'd0, 32'h0302_0100, 1, 0);
        reset_abort("rst_rsp", 1'b1);
        do_load("lw_1000_b", 32'h0000_1000, 3'b010, 2'd0, 32'h0302_0100, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
